// File: rtl/jp_pad_emu_pkg.sv
// Shared button indices and vector type for the NES pad emulator.
package jp_pad_emu_pkg;

  localparam int JP_NUM_BTNS  = 8;
  localparam int JP_BTN_A      = 0;
  localparam int JP_BTN_B      = 1;
  localparam int JP_BTN_SELECT = 2;
  localparam int JP_BTN_START  = 3;
  localparam int JP_BTN_UP     = 4;
  localparam int JP_BTN_DOWN   = 5;
  localparam int JP_BTN_LEFT   = 6;
  localparam int JP_BTN_RIGHT  = 7;

  typedef logic [JP_NUM_BTNS-1:0] btn_vec_t;

endpackage

// File: rtl/jp_debounce.sv
// One button: 2-FF synchroniser followed by a stability counter that gates the accepted level.
module jp_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw_in,
  output logic deb_out
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // stage p0/p1: synchronise the raw pin
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // stage p2: accept the synced level only after it has differed for CYCLES samples
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt     <= '0;
      deb_out <= 1'b0;
    end else if (sync_p1 == deb_out) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      deb_out <= sync_p1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jp_pad_emu.sv
// NES controller responder: debounced buttons, A/B turbo, 4021-style latch/shift serial output.
module jp_pad_emu
  import jp_pad_emu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int TURBO_HALF_CYCLES = 3333333
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] btn_in,
  input  logic [1:0] turbo_en_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  output logic       jp_data_out,
  output logic [7:0] btn_state_out
);

  localparam int TURBO_W = (TURBO_HALF_CYCLES > 1) ? $clog2(TURBO_HALF_CYCLES) : 1;
  localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_HALF_CYCLES - 1);

  btn_vec_t           deb;
  btn_vec_t           eff;
  logic [TURBO_W-1:0] turbo_cnt;
  logic               turbo_phase;
  logic               latch_p0;
  logic               latch_p1;
  logic               clk_p0;
  logic               clk_p1;
  logic               clk_p2;
  logic               clk_rise;
  logic [7:0]         sr;

  for (genvar i = 0; i < JP_NUM_BTNS; i++) begin : g_deb
    jp_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .raw_in  (btn_in[i]),
      .deb_out (deb[i])
    );
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (turbo_cnt == TURBO_LAST) begin
      turbo_cnt   <= '0;
      turbo_phase <= ~turbo_phase;
    end else begin
      turbo_cnt <= turbo_cnt + 1'b1;
    end
  end

  // Turbo masks A/B off during the low half of the phase; the other buttons pass through.
  always_comb begin
    eff               = deb;
    eff[JP_BTN_A]     = deb[JP_BTN_A] & (~turbo_en_in[0] | turbo_phase);
    eff[JP_BTN_B]     = deb[JP_BTN_B] & (~turbo_en_in[1] | turbo_phase);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      btn_state_out <= '0;
    end else begin
      btn_state_out <= eff;
    end
  end

  // stage p0/p1: synchronise console strobes; p2 holds the previous synced clk for edge detect
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      latch_p0 <= 1'b0;
      latch_p1 <= 1'b0;
      clk_p0   <= 1'b0;
      clk_p1   <= 1'b0;
      clk_p2   <= 1'b0;
    end else begin
      latch_p0 <= jp_latch_in;
      latch_p1 <= latch_p0;
      clk_p0   <= jp_clk_in;
      clk_p1   <= clk_p0;
      clk_p2   <= clk_p1;
    end
  end

  assign clk_rise = clk_p1 & ~clk_p2;

  // Latch high is a transparent parallel load and wins over a coincident clock edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sr <= 8'hFF;
    end else if (latch_p1) begin
      sr <= ~eff;
    end else if (clk_rise) begin
      sr <= {1'b1, sr[7:1]};
    end
  end

  assign jp_data_out = sr[0];

endmodule

// File: tb/tb_jp_pad_emu.sv
// Directed bench for jp_pad_emu with a behavioural pad model checked every cycle.
module tb_jp_pad_emu;

  localparam int DB = 4;
  localparam int TH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] btn = 8'h00;
  logic [1:0] turbo = 2'b00;
  logic       jp_latch = 1'b0;
  logic       jp_clk = 1'b0;
  logic       jp_data;
  logic [7:0] btn_state;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  jp_pad_emu #(
    .DEBOUNCE_CYCLES   (DB),
    .TURBO_HALF_CYCLES (TH)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .btn_in        (btn),
    .turbo_en_in   (turbo),
    .jp_latch_in   (jp_latch),
    .jp_clk_in     (jp_clk),
    .jp_data_out   (jp_data),
    .btn_state_out (btn_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: pin delays, consecutive-sample debounce, time-derived turbo phase,
  // and the pad's serial image described as "loaded buttons plus number of bits clocked out".
  logic [7:0] m_b1, m_b2, m_deb, m_state, m_img, m_eff;
  logic       m_l1, m_l2, m_c1, m_c2, m_c3;
  int         m_run [8];
  int         m_k, m_shifts, m_phase;

  function automatic logic m_data();
    return (m_shifts < 8) ? ~m_img[m_shifts] : 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b1 = 0; m_b2 = 0; m_deb = 0; m_state = 0; m_img = 0;
      m_l1 = 0; m_l2 = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_k = 0;
      m_shifts = 8;
    end else begin
      m_phase = (m_k / TH) % 2;
      m_eff = m_deb;
      if (turbo[0] && m_phase == 0) m_eff[0] = 1'b0;
      if (turbo[1] && m_phase == 0) m_eff[1] = 1'b0;
      m_state = m_eff;
      if (m_l2) begin
        m_img = m_eff;
        m_shifts = 0;
      end else if (m_c2 && !m_c3 && m_shifts < 8) begin
        m_shifts++;
      end
      for (int i = 0; i < 8; i++) begin
        if (m_b2[i] == m_deb[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_deb[i] = m_b2[i];
            m_run[i] = 0;
          end
        end
      end
      m_c3 = m_c2; m_c2 = m_c1; m_c1 = jp_clk;
      m_l2 = m_l1; m_l1 = jp_latch;
      m_b2 = m_b1; m_b1 = btn;
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_data", {7'b0, jp_data}, {7'b0, m_data()});
      check("model_state", btn_state, m_state);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic read_seq(input int n, output logic [11:0] bits);
    bits = '1;
    jp_latch = 1'b1; cyc(8);
    jp_latch = 1'b0; cyc(8);
    bits[0] = jp_data;
    for (int i = 1; i < n; i++) begin
      jp_clk = 1'b1; cyc(8);
      bits[i] = jp_data;
      jp_clk = 1'b0; cyc(8);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rd;
    logic [11:0] exp_seq;
    logic [7:0]  ref_btn;
    logic        t_st [48];
    logic        t_d  [48];
    logic        t_b1 [48];
    int          n, last_chg, nchg, bad_gap, bad_b1, bad_d;

    exp_seq = 12'b1111_0111_0110;
    ref_btn = 8'h89;

    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    cyc(3);
    check("reset_data", {7'b0, jp_data}, 8'h01);
    check("reset_state", btn_state, 8'h00);
    rst = 1'b0;
    cyc(4);

    // Debounce: short glitch rejected, held press accepted within 7 cycles
    btn = 8'h01; cyc(3);
    btn = 8'h00; cyc(12);
    check("glitch_reject", btn_state, 8'h00);
    btn = 8'h01;
    n = 0;
    while (n < 20 && btn_state[0] !== 1'b1) begin
      cyc(1);
      n++;
    end
    check("deb_accept", btn_state, 8'h01);
    total++;
    if (n <= 7) passed++;
    else $display("FAIL deb_latency: took %0d cycles, required <= 7", n);
    cyc(10);

    // Read sequence with A, Start, Right
    btn = ref_btn; cyc(16);
    check("state_89", btn_state, 8'h89);
    read_seq(12, rd);
    for (int i = 0; i < 12; i++)
      check($sformatf("read_bit%0d", i), {7'b0, rd[i]}, {7'b0, exp_seq[i]});

    // Latch/clk collision then button change mid-shift
    jp_clk = 1'b0; cyc(8);
    jp_latch = 1'b1; jp_clk = 1'b1; cyc(8);
    check("coll_load", {7'b0, jp_data}, 8'h00);
    jp_latch = 1'b0; cyc(8);
    check("coll_noshift", {7'b0, jp_data}, 8'h00);
    jp_clk = 1'b0; cyc(8);
    jp_clk = 1'b1; cyc(8);
    check("coll_bitB", {7'b0, jp_data}, 8'h01);
    jp_clk = 1'b0; cyc(8);
    btn = 8'h00; cyc(16);
    for (int i = 2; i <= 8; i++) begin
      jp_clk = 1'b1; cyc(8);
      check($sformatf("midshift_bit%0d", i), {7'b0, jp_data},
            {7'b0, (i < 8) ? ~ref_btn[i] : 1'b1});
      jp_clk = 1'b0; cyc(8);
    end

    // Turbo on A only, A and B held, latch held high
    turbo = 2'b01; btn = 8'h03; cyc(16);
    jp_latch = 1'b1; cyc(4);
    for (int i = 0; i < 48; i++) begin
      t_st[i] = btn_state[0];
      t_b1[i] = btn_state[1];
      t_d[i]  = jp_data;
      cyc(1);
    end
    jp_latch = 1'b0;
    last_chg = -1; nchg = 0; bad_gap = 0; bad_b1 = 0; bad_d = 0;
    for (int i = 0; i < 48; i++) begin
      if (t_b1[i] !== 1'b1) bad_b1++;
      if (t_d[i] !== ~t_st[i]) bad_d++;
      if (i > 0 && t_st[i] !== t_st[i-1]) begin
        if (last_chg >= 0 && i - last_chg != TH) bad_gap++;
        last_chg = i;
        nchg++;
      end
    end
    check("turbo_changes", 8'(nchg), 8'd6);
    check("turbo_gap_errs", 8'(bad_gap), 8'd0);
    check("turbo_b_const", 8'(bad_b1), 8'd0);
    check("turbo_data_step", 8'(bad_d), 8'd0);
    turbo = 2'b00;

    // Reset mid-shift, then full reread
    btn = ref_btn; cyc(16);
    jp_latch = 1'b1; cyc(8);
    jp_latch = 1'b0; cyc(8);
    for (int i = 0; i < 3; i++) begin
      jp_clk = 1'b1; cyc(8);
      jp_clk = 1'b0; cyc(8);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_data", {7'b0, jp_data}, 8'h01);
    check("rst_mid_state", btn_state, 8'h00);
    cyc(2);
    rst = 1'b0;
    cyc(16);
    read_seq(12, rd);
    for (int i = 0; i < 12; i++)
      check($sformatf("reread_bit%0d", i), {7'b0, rd[i]}, {7'b0, exp_seq[i]});

    cyc(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
